// File: rtl/vlog_shift_accum_pkg.sv
// Shared types and the shift helper for the multi-lane shift-accumulate engine.
// Saturating arithmetic is enabled with the macro VLOG_SHACC_SAT_EN.
package vlog_shacc_pkg;

  typedef enum logic [1:0] {SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, SLA = 2'b11} shacc_mode_t;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} shacc_state_t;

  // Widest lane operand the shift helper can handle.
  localparam int unsigned SHACC_MAXW = 64;

  // Shift a w-bit operand held zero-extended in x. The caller truncates to w bits.
  // For SRA the operand is sign-extended from bit w-1 first, so the MSB replicates.
  function automatic logic [SHACC_MAXW-1:0] shacc_shift(input logic [SHACC_MAXW-1:0] x,
                                                        input int unsigned amt,
                                                        input shacc_mode_t mode,
                                                        input int unsigned w);
    logic [SHACC_MAXW-1:0] xs;
    logic [SHACC_MAXW-1:0] r;
    xs = x;
    if (x[w-1]) xs = x | ({SHACC_MAXW{1'b1}} << w);
    case (mode)
      SLL, SLA: r = x << amt;
      SRL:      r = x >> amt;
      default:  r = SHACC_MAXW'($signed(xs) >>> amt);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vlog_shift_accum_lane.sv
// One lane of the shift-accumulate engine: operand, accumulator and sticky
// saturation flag. The sat port only exists when VLOG_SHACC_SAT_EN is defined.
module vlog_shacc_lane
  import vlog_shacc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACCW  = 12,
  parameter int AMTW  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic [AMTW-1:0]   amt_i,
  input  shacc_mode_t       mode_i,
  output logic [ACCW-1:0]   acc_o
`ifdef VLOG_SHACC_SAT_EN
  ,output logic             sat_o
`endif
);

  logic [WIDTH-1:0] x_q, x_d;
  logic [ACCW-1:0]  acc_q, acc_d;
  logic [ACCW-1:0]  ext;
  logic             sgn;
`ifdef VLOG_SHACC_SAT_EN
  logic [ACCW:0]    sum;
  logic             ovf;
  logic             sat_q;
`endif

  // Next operand, extended addend and next accumulator (wrapping or clamping).
  always_comb begin
    sgn = (mode_i == SRA) || (mode_i == SLA);
    if (sgn) ext = ACCW'($signed(x_q));
    else     ext = ACCW'(x_q);
    x_d = WIDTH'(shacc_shift(SHACC_MAXW'(x_q), 32'(amt_i), mode_i, WIDTH));
`ifdef VLOG_SHACC_SAT_EN
    sum   = {1'b0, acc_q} + {1'b0, ext};
    acc_d = sum[ACCW-1:0];
    ovf   = 1'b0;
    if (sgn) begin
      // Signed overflow: operands agree in sign but the result does not.
      ovf = (acc_q[ACCW-1] == ext[ACCW-1]) && (sum[ACCW-1] != acc_q[ACCW-1]);
      if (ovf) acc_d = acc_q[ACCW-1] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
    end else begin
      ovf = sum[ACCW];
      if (ovf) acc_d = '1;
    end
`else
    acc_d = acc_q + ext;
`endif
  end

  // Load on accept, step once per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      acc_q <= '0;
`ifdef VLOG_SHACC_SAT_EN
      sat_q <= 1'b0;
`endif
    end else if (load_i) begin
      x_q   <= data_i;
      acc_q <= '0;
`ifdef VLOG_SHACC_SAT_EN
      sat_q <= 1'b0;
`endif
    end else if (step_i) begin
      x_q   <= x_d;
      acc_q <= acc_d;
`ifdef VLOG_SHACC_SAT_EN
      sat_q <= sat_q | ovf;
`endif
    end
  end

  assign acc_o = acc_q;
`ifdef VLOG_SHACC_SAT_EN
  assign sat_o = sat_q;
`endif

endmodule

// File: rtl/vlog_shift_accum.sv
// Multi-lane shift-and-accumulate engine with valid/ready on both sides.
// One FSM, iteration counter and latched mode/amt shared by all lanes.
// Define VLOG_SHACC_SAT_EN for saturating adds and the out_sat port.
module vlog_shift_accum
  import vlog_shacc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 2,
  parameter int ACCW  = 12,
  parameter int CNTW  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*WIDTH-1:0]    in_data,
  input  logic [$clog2(WIDTH)-1:0]  in_amt,
  input  logic [1:0]                in_mode,
  input  logic [CNTW-1:0]           in_count,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*ACCW-1:0]     out_data
`ifdef VLOG_SHACC_SAT_EN
  ,output logic [LANES-1:0]         out_sat
`endif
);

  localparam int AMTW = $clog2(WIDTH);

  shacc_state_t    state_q;
  shacc_mode_t     mode_q;
  logic [AMTW-1:0] amt_q;
  logic [CNTW-1:0] cnt_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            load, step;

  assign load = (state_q == IDLE) && in_valid;
  assign step = (state_q == RUN);

  // Control FSM. out_valid rises one cycle after entering DONE so the
  // result appears in_count+1 cycles after the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= SLL;
      amt_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          mode_q     <= shacc_mode_t'(in_mode);
          amt_q      <= in_amt;
          cnt_q      <= in_count;
          in_ready_q <= 1'b0;
          if (in_count == '0) state_q <= DONE;
          else                state_q <= RUN;
        end
        RUN: begin
          cnt_q <= cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) state_q <= DONE;
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    vlog_shacc_lane #(.WIDTH(WIDTH), .ACCW(ACCW), .AMTW(AMTW)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .load_i (load),
      .step_i (step),
      .data_i (in_data[l*WIDTH +: WIDTH]),
      .amt_i  (amt_q),
      .mode_i (mode_q),
      .acc_o  (out_data[l*ACCW +: ACCW])
`ifdef VLOG_SHACC_SAT_EN
      ,.sat_o (out_sat[l])
`endif
    );
  end

endmodule

// File: tb/tb_vlog_shift_accum.sv
// Bench for vlog_shift_accum: vector table through a scoreboard, plus
// hand sequences for output backpressure and reset mid-operation.
module tb_vlog_shift_accum;

  localparam int WIDTH = 8, LANES = 2, ACCW = 12, CNTW = 5;
  localparam logic [1:0] M_SLL = 2'd0, M_SRL = 2'd1, M_SRA = 2'd2, M_SLA = 2'd3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid, in_ready, out_valid, out_ready;
  logic [LANES*WIDTH-1:0]  in_data;
  logic [2:0]              in_amt;
  logic [1:0]              in_mode;
  logic [CNTW-1:0]         in_count;
  logic [LANES*ACCW-1:0]   out_data;
`ifdef VLOG_SHACC_SAT_EN
  logic [LANES-1:0]        out_sat;
`endif

  always #5 clk = ~clk;

  vlog_shift_accum #(.WIDTH(WIDTH), .LANES(LANES), .ACCW(ACCW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_mode(in_mode), .in_count(in_count), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
`ifdef VLOG_SHACC_SAT_EN
    , .out_sat(out_sat)
`endif
  );

  typedef struct {
    logic [7:0]  d0, d1;
    logic [2:0]  amt;
    logic [1:0]  mode;
    logic [4:0]  cnt;
    logic [11:0] e0, e1;
    logic [1:0]  s;
  } vec_t;

  vec_t tbl[8];
  vec_t sbq[$];
  int   errs = 0, checks = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic vec_t mk(input logic [7:0] d0, d1, input logic [2:0] amt,
                              input logic [1:0] mode, input logic [4:0] cnt,
                              input logic [11:0] e0, e1, input logic [1:0] s);
    vec_t v;
    v.d0 = d0; v.d1 = d1; v.amt = amt; v.mode = mode; v.cnt = cnt;
    v.e0 = e0; v.e1 = e1; v.s = s;
    return v;
  endfunction

  // Scoreboard: compare on the cycle whose rising edge completes the handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++; errs++;
        $display("FAIL sb_unexpected: got result %0h want none", out_data);
      end else begin
        vec_t e;
        e = sbq.pop_front();
        chk("lane0_data", 32'(out_data[11:0]), 32'(e.e0));
        chk("lane1_data", 32'(out_data[23:12]), 32'(e.e1));
`ifdef VLOG_SHACC_SAT_EN
        chk("sat_flags", 32'(out_sat), 32'(e.s));
`endif
      end
    end
  end

  task automatic drive(input vec_t v);
    in_data  = {v.d1, v.d0};
    in_amt   = v.amt;
    in_mode  = v.mode;
    in_count = v.cnt;
    in_valid = 1'b1;
  endtask

  task automatic accept(input vec_t v);
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      checks++; errs++;
      $display("FAIL accept_timeout: got in_ready=0 want 1");
    end
    @(posedge clk); #1;
    sbq.push_back(v);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int exp_lat);
    int lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    drive(v);
    accept(v);
    wait_valid(int'(v.cnt) + 1);
    handshake();
  endtask

  initial begin
    vec_t v;
    tbl[0] = mk(8'h01, 8'h00, 3'd1, M_SLL, 5'd4,  12'h00F, 12'h000, 2'b00);
    tbl[1] = mk(8'h01, 8'h80, 3'd1, M_SRA, 5'd3,  12'h001, 12'hF20, 2'b00);
    tbl[2] = mk(8'hFF, 8'h80, 3'd1, M_SRL, 5'd3,  12'h1BD, 12'h0E0, 2'b00);
`ifdef VLOG_SHACC_SAT_EN
    tbl[3] = mk(8'hFF, 8'h00, 3'd0, M_SLL, 5'd20, 12'hFFF, 12'h000, 2'b01);
    tbl[6] = mk(8'h7F, 8'h80, 3'd0, M_SRA, 5'd20, 12'h7FF, 12'h800, 2'b11);
`else
    tbl[3] = mk(8'hFF, 8'h00, 3'd0, M_SLL, 5'd20, 12'h3EC, 12'h000, 2'b00);
    tbl[6] = mk(8'h7F, 8'h80, 3'd0, M_SRA, 5'd20, 12'h9EC, 12'h600, 2'b00);
`endif
    tbl[4] = mk(8'hAB, 8'hCD, 3'd5, M_SRL, 5'd0,  12'h000, 12'h000, 2'b00);
    tbl[5] = mk(8'h40, 8'h03, 3'd1, M_SLA, 5'd3,  12'hFC0, 12'h015, 2'b00);
    tbl[7] = mk(8'hFF, 8'h80, 3'd7, M_SRL, 5'd3,  12'h100, 12'h081, 2'b00);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_amt = '0; in_mode = '0; in_count = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
`ifdef VLOG_SHACC_SAT_EN
    chk("rst_out_sat", 32'(out_sat), 32'd0);
`endif
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 8; i++) run_op(tbl[i]);

    // Backpressure: result held while out_ready low; a new offer waits.
    drive(tbl[0]);
    accept(tbl[0]);
    wait_valid(5);
    drive(tbl[2]);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_data", 32'(out_data), 32'({tbl[0].e1, tbl[0].e0}));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
    end
    handshake();
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    chk("post_hs_data", 32'(out_data), 32'({tbl[0].e1, tbl[0].e0}));
    accept(tbl[2]);
    chk("accept_next_cycle", 32'(in_ready), 32'd0);
    wait_valid(4);
    handshake();

    // Reset in the middle of a RUN phase.
    v = mk(8'h01, 8'h01, 3'd1, M_SLL, 5'd10, 12'h000, 12'h000, 2'b00);
    drive(v);
    accept(v);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    void'(sbq.pop_back());
    @(negedge clk); rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("midrst_no_result", 32'(out_valid), 32'd0);
    end
    run_op(tbl[6]);
    run_op(tbl[1]);

    repeat (2) @(posedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
